// File: rtl/pivot_fault_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bira_pkg
// Description : Shared definitions for the BIRA front end: structure widths,
//               spare-structure encoding and lookup, the collector FSM state
//               type and the pivot CAM entry record.
// Revision    : 1.0 - initial release
// ============================================================================
package bira_pkg;

    localparam int PCAM_DEPTH = 8;   // pivot entries == total spares
    localparam int ADDR_W     = 10;  // row / column address width
    localparam int BANK_W     = 2;   // bank address width
    localparam int CNT_W      = 3;   // saturating per-entry hit counter
    localparam int CFLAG_W    = 8;   // column flag stored with each entry
    localparam int SPARE_W    = 4;   // holds a spare count of 0..8
    localparam int PCNT_W     = 4;   // holds a pivot count of 0..8

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Spare structure select: how the spares split into rows / columns.
    typedef enum logic [1:0] {
        SS_R4C4 = 2'b00,
        SS_R3C5 = 2'b01,
        SS_R5C3 = 2'b10,
        SS_R2C6 = 2'b11
    } spare_struct_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_DONE    = 2'b10,
        ST_TERM    = 2'b11
    } pfc_state_e;

    typedef struct packed {
        logic                valid;
        logic [ADDR_W-1:0]   row;
        logic [ADDR_W-1:0]   col;
        logic [BANK_W-1:0]   bank;
        logic [CFLAG_W-1:0]  cflag;
        logic [CNT_W-1:0]    rcnt;
        logic [CNT_W-1:0]    ccnt;
    } pivot_entry_t;

    // Returns {R, C}: number of row spares and column spares.
    function automatic logic [2*SPARE_W-1:0] spare_alloc(input logic [1:0] ss);
        logic [SPARE_W-1:0] r;
        logic [SPARE_W-1:0] c;
        r = SPARE_W'(4);
        c = SPARE_W'(4);
        case (spare_struct_e'(ss))
            SS_R4C4: begin r = SPARE_W'(4); c = SPARE_W'(4); end
            SS_R3C5: begin r = SPARE_W'(3); c = SPARE_W'(5); end
            SS_R5C3: begin r = SPARE_W'(5); c = SPARE_W'(3); end
            default: begin r = SPARE_W'(2); c = SPARE_W'(6); end
        endcase
        return {r, c};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pivot_fault_collector_pcam_entry.sv
`default_nettype none
// ============================================================================
// Module      : pcam_entry
// Description : One pivot CAM entry. Holds the pivot fault record, reports
//               bank-qualified row / column matches against the incoming
//               fault, keeps saturating row / column hit counters and derives
//               sticky must-repair flags from them.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_alloc           - load this entry with the incoming fault
//               i_row_inc/i_col_inc - bump the row / column hit counter
//               i_row/i_col/i_bank/i_cflag - incoming fault fields
//               i_spare_r/i_spare_c - row / column spare counts of the test
//               o_row_hit/o_col_hit - combinational match of incoming fault
//               o_valid/o_row/o_col/o_bank/o_cflag - registered entry view
//               o_must_row/o_must_col - registered sticky must-repair flags
// Revision    : 1.0 - initial release
// ============================================================================
module pcam_entry
    import bira_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_alloc,
    input  logic                i_row_inc,
    input  logic                i_col_inc,
    input  logic [ADDR_W-1:0]   i_row,
    input  logic [ADDR_W-1:0]   i_col,
    input  logic [BANK_W-1:0]   i_bank,
    input  logic [CFLAG_W-1:0]  i_cflag,
    input  logic [SPARE_W-1:0]  i_spare_r,
    input  logic [SPARE_W-1:0]  i_spare_c,
    output logic                o_row_hit,
    output logic                o_col_hit,
    output logic                o_valid,
    output logic [ADDR_W-1:0]   o_row,
    output logic [ADDR_W-1:0]   o_col,
    output logic [BANK_W-1:0]   o_bank,
    output logic [CFLAG_W-1:0]  o_cflag,
    output logic                o_must_row,
    output logic                o_must_col
);

    pivot_entry_t r_entry;
    logic         r_must_row;
    logic         r_must_col;
    logic         w_bank_hit;

    assign w_bank_hit = r_entry.valid && (r_entry.bank == i_bank);
    assign o_row_hit  = w_bank_hit && (r_entry.row == i_row);
    assign o_col_hit  = w_bank_hit && (r_entry.col == i_col);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_entry    <= '0;
            r_must_row <= 1'b0;
            r_must_col <= 1'b0;
        end else begin
            if (i_alloc) begin
                r_entry.valid <= 1'b1;
                r_entry.row   <= i_row;
                r_entry.col   <= i_col;
                r_entry.bank  <= i_bank;
                r_entry.cflag <= i_cflag;
                r_entry.rcnt  <= CNT_W'(1);
                r_entry.ccnt  <= CNT_W'(1);
            end else begin
                if (i_row_inc && (r_entry.rcnt != CNT_MAX)) begin
                    r_entry.rcnt <= r_entry.rcnt + CNT_W'(1);
                end
                if (i_col_inc && (r_entry.ccnt != CNT_MAX)) begin
                    r_entry.ccnt <= r_entry.ccnt + CNT_W'(1);
                end
            end
            // A row with more faults than there are column spares can only
            // be fixed by a row spare (and vice versa). Evaluated on the
            // counter as it stands, so the flag trails the update by a cycle.
            r_must_row <= r_must_row | (SPARE_W'(r_entry.rcnt) > i_spare_c);
            r_must_col <= r_must_col | (SPARE_W'(r_entry.ccnt) > i_spare_r);
        end
    end

    assign o_valid    = r_entry.valid;
    assign o_row      = r_entry.row;
    assign o_col      = r_entry.col;
    assign o_bank     = r_entry.bank;
    assign o_cflag    = r_entry.cflag;
    assign o_must_row = r_must_row;
    assign o_must_col = r_must_col;

endmodule
`default_nettype wire

// File: rtl/pivot_fault_collector.sv
`default_nettype none
// ============================================================================
// Module      : pivot_fault_collector
// Description : Captures BIST faults into the pivot CAM, classifies them as
//               pivot / non-pivot, tracks per-entry hit counts and must-repair
//               flags, flags pivot overflow (early_term) and freezes the CAM
//               on test_end (collect_done).
// Ports       : clk, rst - clock, synchronous active-high reset
//               spare_struct, fault_detect, row_add_in, col_add_in, col_flag,
//               bank_in, test_end - BIST side
//               pivot_valid/row/col/bank/cflag, must_row, must_col,
//               pivot_cnt, early_term, collect_done - analysis side
// Options     : PFC_NONPIVOT_CNT_EN adds output nonpivot_cnt, a saturating
//               count of non-duplicate non-pivot faults.
// Revision    : 1.0 - initial release
// ============================================================================
module pivot_fault_collector
    import bira_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    spare_struct,
    input  logic                          fault_detect,
    input  logic [ADDR_W-1:0]             row_add_in,
    input  logic [ADDR_W-1:0]             col_add_in,
    input  logic [CFLAG_W-1:0]            col_flag,
    input  logic [BANK_W-1:0]             bank_in,
    input  logic                          test_end,
    output logic [PCAM_DEPTH-1:0]         pivot_valid,
    output logic [PCAM_DEPTH*ADDR_W-1:0]  pivot_row,
    output logic [PCAM_DEPTH*ADDR_W-1:0]  pivot_col,
    output logic [PCAM_DEPTH*BANK_W-1:0]  pivot_bank,
    output logic [PCAM_DEPTH*CFLAG_W-1:0] pivot_cflag,
    output logic [PCAM_DEPTH-1:0]         must_row,
    output logic [PCAM_DEPTH-1:0]         must_col,
    output logic [PCNT_W-1:0]             pivot_cnt,
    output logic                          early_term,
    output logic                          collect_done
`ifdef PFC_NONPIVOT_CNT_EN
    ,
    output logic [7:0]                    nonpivot_cnt
`endif
);

    pfc_state_e                 r_state;
    logic [SPARE_W-1:0]         r_spare_r;
    logic [SPARE_W-1:0]         r_spare_c;
    logic [PCNT_W-1:0]          r_pivot_cnt;
    logic                       r_early_term;
    logic                       r_collect_done;

    logic [PCAM_DEPTH-1:0]      w_row_hit;
    logic [PCAM_DEPTH-1:0]      w_col_hit;
    logic [PCAM_DEPTH-1:0]      w_free;
    logic [PCAM_DEPTH-1:0]      w_lowest_free;
    logic [PCAM_DEPTH-1:0]      w_alloc;
    logic [PCAM_DEPTH-1:0]      w_row_inc;
    logic [PCAM_DEPTH-1:0]      w_col_inc;
    logic [2*SPARE_W-1:0]       w_spare;
    logic                       w_accept;
    logic                       w_fault;
    logic                       w_dup;
    logic                       w_any_hit;
    logic                       w_nonpivot;
    logic                       w_full;
    logic                       w_new_pivot;
    logic                       w_overflow;

    // Faults are only taken before the test has ended or overflowed.
    assign w_accept    = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
    assign w_fault     = fault_detect && w_accept;

    assign w_dup       = |(w_row_hit & w_col_hit);
    assign w_any_hit   = |(w_row_hit | w_col_hit);
    assign w_nonpivot  = w_fault && !w_dup && w_any_hit;
    assign w_full      = (r_pivot_cnt == PCNT_W'(PCAM_DEPTH));
    assign w_new_pivot = w_fault && !w_any_hit && !w_full;
    assign w_overflow  = w_fault && !w_any_hit && w_full;

    // Isolate the lowest clear bit of the valid vector.
    assign w_free        = ~pivot_valid;
    assign w_lowest_free = w_free & (~w_free + PCAM_DEPTH'(1));
    assign w_alloc       = w_new_pivot ? w_lowest_free : '0;

    // In a non-duplicate fault no entry can hit on both row and column, so
    // the two increment vectors never touch the same counter of one entry
    // with conflicting meaning.
    assign w_row_inc = w_nonpivot ? w_row_hit : '0;
    assign w_col_inc = w_nonpivot ? w_col_hit : '0;

    assign w_spare = spare_alloc(spare_struct);

    genvar gi;
    generate
        for (gi = 0; gi < PCAM_DEPTH; gi++) begin : g_entry
            pcam_entry u_entry (
                .clk        (clk),
                .rst        (rst),
                .i_alloc    (w_alloc[gi]),
                .i_row_inc  (w_row_inc[gi]),
                .i_col_inc  (w_col_inc[gi]),
                .i_row      (row_add_in),
                .i_col      (col_add_in),
                .i_bank     (bank_in),
                .i_cflag    (col_flag),
                .i_spare_r  (r_spare_r),
                .i_spare_c  (r_spare_c),
                .o_row_hit  (w_row_hit[gi]),
                .o_col_hit  (w_col_hit[gi]),
                .o_valid    (pivot_valid[gi]),
                .o_row      (pivot_row[gi*ADDR_W +: ADDR_W]),
                .o_col      (pivot_col[gi*ADDR_W +: ADDR_W]),
                .o_bank     (pivot_bank[gi*BANK_W +: BANK_W]),
                .o_cflag    (pivot_cflag[gi*CFLAG_W +: CFLAG_W]),
                .o_must_row (must_row[gi]),
                .o_must_col (must_col[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_spare_r      <= '0;
            r_spare_c      <= '0;
            r_pivot_cnt    <= '0;
            r_early_term   <= 1'b0;
            r_collect_done <= 1'b0;
        end else begin
            if (w_new_pivot) begin
                r_pivot_cnt <= r_pivot_cnt + PCNT_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (fault_detect || test_end) begin
                        // Spare split is latched once for the whole test.
                        r_spare_r <= w_spare[2*SPARE_W-1:SPARE_W];
                        r_spare_c <= w_spare[SPARE_W-1:0];
                        if (test_end) begin
                            r_state        <= ST_DONE;
                            r_collect_done <= 1'b1;
                        end else begin
                            r_state <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (w_overflow) begin
                        r_state      <= ST_TERM;
                        r_early_term <= 1'b1;
                        if (test_end) begin
                            r_collect_done <= 1'b1;
                        end
                    end else if (test_end) begin
                        r_state        <= ST_DONE;
                        r_collect_done <= 1'b1;
                    end
                end
                ST_DONE, ST_TERM: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pivot_cnt    = r_pivot_cnt;
    assign early_term   = r_early_term;
    assign collect_done = r_collect_done;

`ifdef PFC_NONPIVOT_CNT_EN
    logic [7:0] r_nonpivot_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nonpivot_cnt <= '0;
        end else if (w_nonpivot && (r_nonpivot_cnt != 8'hFF)) begin
            r_nonpivot_cnt <= r_nonpivot_cnt + 8'd1;
        end
    end

    assign nonpivot_cnt = r_nonpivot_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pivot_fault_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_pivot_fault_collector
// Description : Self-checking bench for pivot_fault_collector. Directed
//               scenarios plus randomized fault streams, all compared every
//               cycle against a behavioural model of the collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pivot_fault_collector;

    localparam int DEPTH = 8;
    localparam int AW    = 10;
    localparam int BW    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        spare_struct = 2'b00;
    logic              fault_detect = 1'b0;
    logic [AW-1:0]     row_add_in = '0;
    logic [AW-1:0]     col_add_in = '0;
    logic [7:0]        col_flag = '0;
    logic [BW-1:0]     bank_in = '0;
    logic              test_end = 1'b0;
    logic [DEPTH-1:0]      pivot_valid;
    logic [DEPTH*AW-1:0]   pivot_row;
    logic [DEPTH*AW-1:0]   pivot_col;
    logic [DEPTH*BW-1:0]   pivot_bank;
    logic [DEPTH*8-1:0]    pivot_cflag;
    logic [DEPTH-1:0]      must_row;
    logic [DEPTH-1:0]      must_col;
    logic [3:0]            pivot_cnt;
    logic                  early_term;
    logic                  collect_done;

    int n_checks = 0;
    int n_fail   = 0;

    pivot_fault_collector dut (
        .clk          (clk),
        .rst          (rst),
        .spare_struct (spare_struct),
        .fault_detect (fault_detect),
        .row_add_in   (row_add_in),
        .col_add_in   (col_add_in),
        .col_flag     (col_flag),
        .bank_in      (bank_in),
        .test_end     (test_end),
        .pivot_valid  (pivot_valid),
        .pivot_row    (pivot_row),
        .pivot_col    (pivot_col),
        .pivot_bank   (pivot_bank),
        .pivot_cflag  (pivot_cflag),
        .must_row     (must_row),
        .must_col     (must_col),
        .pivot_cnt    (pivot_cnt),
        .early_term   (early_term),
        .collect_done (collect_done)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_phase: 0 = waiting for test start, 1 = collecting, 2 = finished,
    // 3 = overflowed.
    int m_phase;
    int m_R, m_C, m_cnt;
    bit m_et, m_cd;
    bit m_valid [DEPTH];
    int m_row   [DEPTH];
    int m_col   [DEPTH];
    int m_bank  [DEPTH];
    int m_cflag [DEPTH];
    int m_rc    [DEPTH];
    int m_cc    [DEPTH];
    bit m_mr    [DEPTH];
    bit m_mc    [DEPTH];

    task automatic model_reset();
        m_phase = 0; m_R = 0; m_C = 0; m_cnt = 0; m_et = 0; m_cd = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0; m_row[i] = 0; m_col[i] = 0; m_bank[i] = 0;
            m_cflag[i] = 0; m_rc[i] = 0; m_cc[i] = 0; m_mr[i] = 0; m_mc[i] = 0;
        end
    endtask

    task automatic model_step(input bit fd, input bit te, input int r, input int c,
                              input int b, input int f, input int ss);
        bit dup, hit;
        int slot;
        // Must-repair flags reflect the counts as of the previous cycle.
        for (int i = 0; i < DEPTH; i++) begin
            if (m_rc[i] > m_C) m_mr[i] = 1;
            if (m_cc[i] > m_R) m_mc[i] = 1;
        end
        if (m_phase >= 2) return;
        if (m_phase == 0) begin
            if (!(fd || te)) return;
            case (ss)
                0: begin m_R = 4; m_C = 4; end
                1: begin m_R = 3; m_C = 5; end
                2: begin m_R = 5; m_C = 3; end
                default: begin m_R = 2; m_C = 6; end
            endcase
            m_phase = 1;
        end
        if (fd) begin
            dup = 0; hit = 0;
            for (int i = 0; i < DEPTH; i++)
                if (m_valid[i] && m_bank[i] == b && m_row[i] == r && m_col[i] == c) dup = 1;
            if (!dup) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (m_valid[i] && m_bank[i] == b && m_row[i] == r) begin
                        hit = 1;
                        if (m_rc[i] < 7) m_rc[i]++;
                    end
                    if (m_valid[i] && m_bank[i] == b && m_col[i] == c) begin
                        hit = 1;
                        if (m_cc[i] < 7) m_cc[i]++;
                    end
                end
                if (!hit) begin
                    if (m_cnt == DEPTH) begin
                        m_et = 1;
                        m_phase = 3;
                        if (te) m_cd = 1;
                    end else begin
                        slot = -1;
                        for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
                        m_valid[slot] = 1; m_row[slot] = r; m_col[slot] = c;
                        m_bank[slot] = b; m_cflag[slot] = f;
                        m_rc[slot] = 1; m_cc[slot] = 1;
                        m_cnt++;
                    end
                end
            end
        end
        if (te && m_phase == 1) begin
            m_phase = 2;
            m_cd = 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DEPTH-1:0]    ev, emr, emc;
        logic [DEPTH*AW-1:0] er, ec;
        logic [DEPTH*BW-1:0] eb;
        logic [DEPTH*8-1:0]  ef;
        for (int i = 0; i < DEPTH; i++) begin
            ev[i]  = m_valid[i];
            emr[i] = m_mr[i];
            emc[i] = m_mc[i];
            er[i*AW +: AW] = AW'(m_row[i]);
            ec[i*AW +: AW] = AW'(m_col[i]);
            eb[i*BW +: BW] = BW'(m_bank[i]);
            ef[i*8 +: 8]   = 8'(m_cflag[i]);
        end
        check_val({tag, ".cnt"},   128'(pivot_cnt),   128'(m_cnt));
        check_val({tag, ".valid"}, 128'(pivot_valid), 128'(ev));
        check_val({tag, ".row"},   128'(pivot_row),   128'(er));
        check_val({tag, ".col"},   128'(pivot_col),   128'(ec));
        check_val({tag, ".bank"},  128'(pivot_bank),  128'(eb));
        check_val({tag, ".cflag"}, 128'(pivot_cflag), 128'(ef));
        check_val({tag, ".mrow"},  128'(must_row),    128'(emr));
        check_val({tag, ".mcol"},  128'(must_col),    128'(emc));
        check_val({tag, ".eterm"}, 128'(early_term),  128'(m_et));
        check_val({tag, ".done"},  128'(collect_done), 128'(m_cd));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input logic [1:0] ss);
        rst = 1'b1; fault_detect = 1'b0; test_end = 1'b0; spare_struct = ss;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        check_all("reset");
    endtask

    task automatic cyc(input string tag, input bit fd, input bit te, input int b,
                       input int r, input int c, input int f);
        fault_detect = fd; test_end = te;
        bank_in = BW'(b); row_add_in = AW'(r); col_add_in = AW'(c); col_flag = 8'(f);
        @(posedge clk);
        model_step(fd, te, r, c, b, f, int'(spare_struct));
        #1;
        fault_detect = 1'b0; test_end = 1'b0;
        check_all(tag);
    endtask

    initial begin
        // Test 1: two distinct pivots.
        do_reset(2'b00);
        cyc("t1a", 1, 0, 0, 5, 10, 8'h11);
        cyc("t1b", 1, 0, 0, 6, 20, 8'h22);
        check_val("t1_cnt", 128'(pivot_cnt), 128'(2));
        check_val("t1_row0", 128'(pivot_row[AW-1:0]), 128'(5));
        check_val("t1_col0", 128'(pivot_col[AW-1:0]), 128'(10));

        // Test 2: one row collects six faults -> must_row[0].
        do_reset(2'b00);
        for (int c = 1; c <= 6; c++) cyc("t2", 1, 0, 0, 7, c, c);
        cyc("t2idle", 0, 0, 0, 0, 0, 0);
        cyc("t2idle", 0, 0, 0, 0, 0, 0);
        check_val("t2_must_row", 128'(must_row), 128'(8'h01));
        check_val("t2_must_col", 128'(must_col), 128'(0));
        check_val("t2_cnt", 128'(pivot_cnt), 128'(1));

        // Test 3: eight pivots then overflow; later faults ignored.
        do_reset(2'b11);
        for (int i = 0; i < 8; i++) cyc("t3fill", 1, 0, 1, 100 + i, 200 + i, i);
        cyc("t3ovf", 1, 0, 1, 300, 400, 8'hEE);
        check_val("t3_eterm", 128'(early_term), 128'(1));
        check_val("t3_cnt", 128'(pivot_cnt), 128'(8));
        cyc("t3post", 1, 0, 2, 500, 600, 1);
        cyc("t3post", 1, 1, 1, 100, 999, 1);
        check_val("t3_cnt_after", 128'(pivot_cnt), 128'(8));
        check_val("t3_done_after", 128'(collect_done), 128'(0));

        // Test 4: repeated duplicate.
        do_reset(2'b01);
        for (int k = 0; k < 4; k++) cyc("t4", 1, 0, 1, 3, 3, 5);
        cyc("t4idle", 0, 0, 0, 0, 0, 0);
        check_val("t4_cnt", 128'(pivot_cnt), 128'(1));

        // Test 5: fault and test_end together, then an ignored fault.
        do_reset(2'b10);
        cyc("t5a", 1, 0, 0, 1, 1, 1);
        cyc("t5end", 1, 1, 0, 2, 2, 2);
        check_val("t5_done", 128'(collect_done), 128'(1));
        check_val("t5_cnt", 128'(pivot_cnt), 128'(2));
        cyc("t5post", 1, 0, 0, 3, 3, 3);
        check_val("t5_cnt_after", 128'(pivot_cnt), 128'(2));

        // Test 6: same row/col in different banks.
        do_reset(2'b00);
        cyc("t6a", 1, 0, 0, 9, 9, 1);
        cyc("t6b", 1, 0, 2, 9, 9, 2);
        check_val("t6_cnt", 128'(pivot_cnt), 128'(2));
        check_val("t6_bank1", 128'(pivot_bank[2*BW-1:BW]), 128'(2));

        // Test 7: overflow and test_end in the same cycle.
        do_reset(2'b00);
        for (int i = 0; i < 8; i++) cyc("t7fill", 1, 0, 0, 10 + i, 20 + i, i);
        cyc("t7both", 1, 1, 0, 50, 60, 0);
        check_val("t7_eterm", 128'(early_term), 128'(1));
        check_val("t7_done", 128'(collect_done), 128'(1));

        // Randomized runs, including one reset mid-test.
        for (int run = 0; run < 8; run++) begin
            int span;
            span = (run % 2 == 0) ? 3 : 9;
            do_reset(2'($urandom_range(0, 3)));
            for (int k = 0; k < 90; k++) begin
                if (run == 3 && k == 45) do_reset(2'($urandom_range(0, 3)));
                cyc("rand",
                    ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 69) == 0),
                    $urandom_range(0, 1),
                    $urandom_range(0, span),
                    $urandom_range(0, span),
                    $urandom_range(0, 255));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pivot_fault_collector.md
Name: pivot_fault_collector

Overview:
- Upstream stage of the BIRA analysis logic. Captures each fault reported by BIST into a pivot-fault CAM (PCAM).
- Classifies each fault as pivot or non-pivot, counts hits per pivot row/column, and derives must-repair flags.
- Asserts early_term when the pivot count exceeds the total spares.
- On test_end, freezes the CAM and raises collect_done so the validity checker and solution search can consume the PCAM contents.

Parameters:
- PCAM_DEPTH, 8, number of pivot entries; equals total spares per structure.
- ADDR_W, 10, row/column address width.
- BANK_W, 2, bank address width.
- CNT_W, 3, saturating per-entry hit-counter width.

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  synchronous, active-high reset
- spare_struct  in  2  spare structure select; held stable during a test
- fault_detect  in  1  one-cycle fault strobe from BIST; may assert every cycle
- row_add_in  in  ADDR_W  fault row address
- col_add_in  in  ADDR_W  fault column address
- col_flag  in  8  fault column flag; stored with the entry
- bank_in  in  BANK_W  fault bank
- test_end  in  1  BIST done strobe
- pivot_valid  out  PCAM_DEPTH  entry occupied
- pivot_row  out  PCAM_DEPTH*ADDR_W  flattened row addresses; entry i at [i*ADDR_W +: ADDR_W]
- pivot_col  out  PCAM_DEPTH*ADDR_W  flattened column addresses
- pivot_bank  out  PCAM_DEPTH*BANK_W  flattened banks
- pivot_cflag  out  PCAM_DEPTH*8  flattened col_flag values
- must_row  out  PCAM_DEPTH  entry's row must be repaired by a row spare
- must_col  out  PCAM_DEPTH  entry's column must be repaired by a column spare
- pivot_cnt  out  4  number of valid entries, 0..8
- early_term  out  1  pivot overflow; sticky until rst
- collect_done  out  1  collection finished; sticky until rst

Behaviour:
- Reset: all outputs 0; FSM enters IDLE; CAM and counters are cleared. A reset mid-test aborts the test immediately with the same result.
- Spare table (rows R / columns C), sampled on leaving IDLE:
  - 00: R=4, C=4
  - 01: R=3, C=5
  - 10: R=5, C=3
  - 11: R=2, C=6
- FSM states: IDLE, COLLECT, DONE, TERM.
  - IDLE -> COLLECT on the first fault_detect or test_end; that same fault is processed.
  - COLLECT -> DONE on test_end.
  - COLLECT -> TERM on overflow.
  - DONE and TERM are held until rst. In both, faults are ignored.
- Per fault (single cycle; outputs registered, visible the next cycle):
  - Compare against all valid entries with the same bank.
  - Row match and column match on the same entry: duplicate; no change.
  - Row match only (matching entries): each matching entry's row counter increments, saturating at 7. Same rule for column match only, using the column counter. Row and column match on different entries: both updates apply. All of these are non-pivot faults; no allocation.
  - No match: allocate the lowest free entry. The new entry's row and column counters load 1. pivot_cnt increments.
  - No match while pivot_cnt == PCAM_DEPTH: overflow. The CAM is left unchanged, early_term=1, FSM -> TERM.
- Must-repair:
  - must_row[i]=1 when row counter > C.
  - must_col[i]=1 when column counter > R.
  - Flags are registered, appear one cycle after the counter update, and are sticky.
- Simultaneous fault_detect and test_end: the fault is processed first, then the FSM goes to DONE. collect_done rises the next cycle with the final CAM contents visible.
- Simultaneous overflow and test_end: TERM wins. early_term=1 and collect_done=1 in the same cycle.
- Back-to-back faults hitting the same entry: counters accumulate correctly every cycle, with no stall.

Optional Feature:
- Macro PFC_NONPIVOT_CNT_EN.
- Defined: adds output nonpivot_cnt (8 bits, saturating at 255), counting non-duplicate non-pivot faults. Reset value 0; frozen in DONE/TERM.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package bira_pkg holds:
  - ADDR_W, BANK_W, CNT_W, PCAM_DEPTH.
  - The spare_struct encoding, plus a function returning {R, C} for it.
  - An FSM state typedef.
  - The pivot entry struct: valid, row, col, bank, cflag, rcnt, ccnt.
- One natural sub-module, pcam_entry: a single CAM entry's storage, match compare and saturating counters, instantiated PCAM_DEPTH times. Priority allocation and the FSM stay in the top.

Test Plan:
- Reset then struct 00; faults (0,5,10),(0,6,20): two entries; pivot_cnt=2; entry0 row=5, col=10.
- Struct 00; faults bank0 row 7, cols 1..6: one pivot plus five non-pivot. Entry0 row counter=6 > C=4, so must_row[0]=1; must_col=0.
- Struct 11; eight distinct pivots then a ninth distinct fault: early_term=1, FSM in TERM, pivot_cnt=8, CAM unchanged; later faults ignored.
- Duplicate fault (1,3,3) repeated 4x: pivot_cnt=1, counters stay 1.
- fault_detect and test_end in the same cycle with a new address: entry allocated and collect_done=1 next cycle. A subsequent fault is ignored.
- Same row/col, different banks (bank0 and bank2, row 9, col 9): two separate pivots, no match across banks.
